// File: rtl/fall_monitor_pkg.sv
// -----------------------------------------------------------------------------
// fall_monitor_pkg
// Shared definitions for the multi-channel fall monitor:
//   ch_state_e  - per-channel state encoding
//   EVT_CNT_W   - width of the per-channel fall event counters
//   width_of()  - index/counter width helper, max(1, clog2(n))
// -----------------------------------------------------------------------------
package fall_monitor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_RECOVERY,
      ST_ALARM,
      ST_ESCALATED
   } ch_state_e;

   localparam int unsigned EVT_CNT_W = 8;

   // A 1-entry selector or a counter that only ever holds 0 still needs one bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fall_channel_fsm.sv
// -----------------------------------------------------------------------------
// fall_channel_fsm
// One sensor channel: debounces the fall sensor, counts a recovery period in
// seconds, then raises an alarm and later escalates unless acknowledged.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   tick          - one-cycle pulse per second from the shared prescaler
//   sensor        - fall indication (synchronous to clk)
//   ack           - patient/caregiver acknowledge (level)
//   enable        - 0 forces the channel to IDLE and clears its counters
//   alarm         - registered, high in ALARM or ESCALATED
//   escalate      - registered, high in ESCALATED
//   confirm       - combinational pulse on the DEBOUNCE->RECOVERY transition
// -----------------------------------------------------------------------------
module fall_channel_fsm
   import fall_monitor_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 5,
   parameter int unsigned RECOVERY_SECS = 30,
   parameter int unsigned ESCALATE_SECS = 60
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic sensor,
   input  logic ack,
   input  logic enable,
   output logic alarm,
   output logic escalate,
   output logic confirm
);

   localparam int unsigned SEC_MAX = (RECOVERY_SECS > ESCALATE_SECS) ? RECOVERY_SECS
                                                                     : ESCALATE_SECS;
   localparam int unsigned CNT_W   = width_of(STABLE_CYCLES);
   localparam int unsigned SEC_W   = width_of(SEC_MAX);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [SEC_W-1:0] REC_LAST = SEC_W'(RECOVERY_SECS - 1);
   localparam logic [SEC_W-1:0] ESC_LAST = SEC_W'(ESCALATE_SECS - 1);

   ch_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SEC_W-1:0] sec_q, sec_d;
   logic             alarm_q, alarm_d;
   logic             escalate_q, escalate_d;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned; otherwise synthesis would infer latches.
      state_d = state_q;
      cnt_d   = cnt_q;
      sec_d   = sec_q;
      confirm = 1'b0;

      if (!enable) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         sec_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (sensor) begin
                  state_d = ST_DEBOUNCE;
                  cnt_d   = '0;
               end
            end
            // The entry sample plus STABLE_CYCLES samples here must all be high.
            ST_DEBOUNCE: begin
               if (!sensor) begin
                  state_d = ST_IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ST_RECOVERY;
                  sec_d   = '0;
                  confirm = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            // Sensor level is deliberately ignored once a fall is confirmed.
            ST_RECOVERY: begin
               if (ack) begin
                  state_d = ST_IDLE;
               end else if (tick) begin
                  if (sec_q == REC_LAST) begin
                     state_d = ST_ALARM;
                     sec_d   = '0;
                  end else begin
                     sec_d = sec_q + SEC_W'(1);
                  end
               end
            end
            ST_ALARM: begin
               if (ack) begin
                  state_d = ST_IDLE;
               end else if (tick) begin
                  if (sec_q == ESC_LAST) begin
                     state_d = ST_ESCALATED;
                  end else begin
                     sec_d = sec_q + SEC_W'(1);
                  end
               end
            end
            ST_ESCALATED: begin
               if (ack) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               sec_d   = '0;
            end
         endcase
      end

      // Outputs follow the next state so they change on the same edge as it.
      alarm_d    = (state_d == ST_ALARM) || (state_d == ST_ESCALATED);
      escalate_d = (state_d == ST_ESCALATED);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         sec_q      <= '0;
         alarm_q    <= 1'b0;
         escalate_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sec_q      <= sec_d;
         alarm_q    <= alarm_d;
         escalate_q <= escalate_d;
      end
   end

   assign alarm    = alarm_q;
   assign escalate = escalate_q;

endmodule

// File: rtl/fall_monitor_multi.sv
// -----------------------------------------------------------------------------
// fall_monitor_multi
// NUM_CH independent fall-detection channels sharing one seconds prescaler,
// with a lowest-index priority encoder over the alarm vector.
// Optional build macro: FALL_EVENT_COUNT_EN adds an 8-bit saturating count of
// confirmed falls per channel, readable through event_sel/event_count. Without
// it event_count is tied to 0 and the ports are kept for interface stability.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   fall_sensor   - per-channel fall indication (synchronous)
//   patient_ack   - per-channel acknowledge (level)
//   ch_enable     - per-channel enable, 0 holds the channel in IDLE
//   alarm         - registered per-channel alarm
//   escalate      - registered per-channel escalation
//   alarm_any     - OR of alarm
//   alarm_id      - lowest alarming channel index, 0 when none
//   event_sel     - channel selected for event_count
//   event_count   - registered event count of the selected channel
// -----------------------------------------------------------------------------
module fall_monitor_multi
   import fall_monitor_pkg::*;
#(
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned STABLE_CYCLES = 5,
   parameter int unsigned RECOVERY_SECS = 30,
   parameter int unsigned ESCALATE_SECS = 60,
   parameter int unsigned CLKS_PER_SEC  = 1000000
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_CH-1:0]             fall_sensor,
   input  logic [NUM_CH-1:0]             patient_ack,
   input  logic [NUM_CH-1:0]             ch_enable,
   output logic [NUM_CH-1:0]             alarm,
   output logic [NUM_CH-1:0]             escalate,
   output logic                          alarm_any,
   output logic [width_of(NUM_CH)-1:0]   alarm_id,
   input  logic [width_of(NUM_CH)-1:0]   event_sel,
   output logic [EVT_CNT_W-1:0]          event_count
);

   localparam int unsigned ID_W  = width_of(NUM_CH);
   localparam int unsigned PRE_W = width_of(CLKS_PER_SEC);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_SEC - 1);

   // ---------------------------------------------------------------- prescaler
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             tick;

   always_comb begin
      tick  = (pre_q == PRE_LAST);
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   // ----------------------------------------------------------------- channels
   logic [NUM_CH-1:0] confirm;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      fall_channel_fsm #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .RECOVERY_SECS (RECOVERY_SECS),
         .ESCALATE_SECS (ESCALATE_SECS)
      ) u_ch (
         .clk      (clk),
         .reset_n  (reset_n),
         .tick     (tick),
         .sensor   (fall_sensor[g]),
         .ack      (patient_ack[g]),
         .enable   (ch_enable[g]),
         .alarm    (alarm[g]),
         .escalate (escalate[g]),
         .confirm  (confirm[g])
      );
   end

   // --------------------------------------------------------- priority encoder
   always_comb begin
      alarm_any = |alarm;
      alarm_id  = '0;
      // Scanning downward lets the lowest alarming index win.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (alarm[i]) begin
            alarm_id = ID_W'(i);
         end
      end
   end

   // ----------------------------------------------------------- event counters
`ifdef FALL_EVENT_COUNT_EN
   localparam int unsigned SEL_N = 1 << ID_W;

   logic [EVT_CNT_W-1:0] evt_q   [NUM_CH];
   logic [EVT_CNT_W-1:0] evt_d   [NUM_CH];
   logic [EVT_CNT_W-1:0] evt_pad [SEL_N];
   logic [EVT_CNT_W-1:0] event_count_q, event_count_d;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         evt_d[i] = (confirm[i] && (evt_q[i] != '1)) ? evt_q[i] + EVT_CNT_W'(1)
                                                      : evt_q[i];
      end
   end

   // Selector codes past the last channel read as zero.
   for (genvar s = 0; s < SEL_N; s++) begin : g_pad
      if (s < NUM_CH) begin : g_real
         assign evt_pad[s] = evt_q[s];
      end else begin : g_zero
         assign evt_pad[s] = '0;
      end
   end

   assign event_count_d = evt_pad[event_sel];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: this array is a handful of counters, not a RAM, so every
         // entry is reset; a real memory would be left out of the reset.
         for (int i = 0; i < NUM_CH; i++) begin
            evt_q[i] <= '0;
         end
         event_count_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            evt_q[i] <= evt_d[i];
         end
         event_count_q <= event_count_d;
      end
   end

   assign event_count = event_count_q;
`else
   // Confirm pulses and the selector have no consumer in this build.
   logic unused_evt;
   assign unused_evt  = ^{confirm, event_sel};
   assign event_count = '0;
`endif

endmodule
